// File: rtl/renorm_pipe_if.sv
// Stream bundle for renorm_pipe: input beat handshake plus scaled output beat.
// The DUT takes the slave modport, the upstream/downstream side takes master.
interface renorm_if #(
    parameter int LANES = 4,
    parameter int IN_W  = 10,
    parameter int OUT_W = 13
);
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES-1:0][IN_W-1:0]  in_data;
    logic [1:0]                  in_mode;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES-1:0][OUT_W-1:0] out_data;
    logic [LANES-1:0]            out_ovf;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/renorm_pipe.sv
// Two-stage shift-add renormalizer (x*2^k or x*(2^k+1) per lane) with valid/ready flow control.
// Define RENORM_SAT_EN to clamp overflowing lanes; otherwise they wrap to the low OUT_W bits.
module renorm_pipe #(
    parameter int LANES = 4,
    parameter int IN_W  = 10,
    parameter int OUT_W = 13,
    parameter int SHIFT = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    renorm_if.slave bus,
    input  logic    ovf_clr,
    output logic    ovf_sticky
);
    localparam int PW = IN_W + SHIFT + 1;

    typedef enum logic [1:0] {
        MODE_STD    = 2'd0,
        MODE_SHIFT  = 2'd1,
        MODE_BYPASS = 2'd2,
        MODE_PLUS   = 2'd3
    } mode_e;

    logic                        v1, v2, rdy1, rdy2;
    mode_e                       mode;
    logic [LANES-1:0][PW-1:0]    prod, p1;
    logic [LANES-1:0][OUT_W-1:0] conv, out_q;
    logic [LANES-1:0]            ovf, ovf_q;

    assign mode          = mode_e'(bus.in_mode);
    assign rdy2          = !v2 || bus.out_ready;
    assign rdy1          = !v1 || rdy2;
    assign bus.in_ready  = rdy1;
    assign bus.out_valid = v2;
    assign bus.out_data  = out_q;
    assign bus.out_ovf   = ovf_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam bit EVEN = (i % 2) == 0;
        logic [PW-1:0]    xs, sh, pl, pm;
        logic [OUT_W-1:0] c;
        logic             o;

        assign xs = PW'($signed(bus.in_data[i]));
        assign sh = xs <<< SHIFT;
        assign pl = sh + xs;

        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        always_comb begin
            pm = sh;
            unique case (mode)
                MODE_STD:    pm = EVEN ? pl : sh;
                MODE_SHIFT:  pm = sh;
                MODE_BYPASS: pm = xs;
                MODE_PLUS:   pm = pl;
                default:     pm = sh;
            endcase
        end
        assign prod[i] = pm;

        if (PW <= OUT_W) begin : g_fit
            assign c = OUT_W'($signed(p1[i]));
            assign o = 1'b0;
        end else begin : g_narrow
            // In range only when the bits above the output sign bit all copy it.
            logic [PW-OUT_W:0] hi;
            assign hi = p1[i][PW-1:OUT_W-1];
            assign o  = !((&hi) || !(|hi));
`ifdef RENORM_SAT_EN
            assign c = o ? (p1[i][PW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                        : {1'b0, {(OUT_W-1){1'b1}}})
                         : p1[i][OUT_W-1:0];
`else
            assign c = p1[i][OUT_W-1:0];
`endif
        end
        assign conv[i] = c;
        assign ovf[i]  = o;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            out_q <= '0;
            ovf_q <= '0;
        end else begin
            if (rdy1) v1 <= bus.in_valid;
            if (rdy2) begin
                v2 <= v1;
                if (v1) begin
                    out_q <= conv;
                    ovf_q <= ovf;
                end
            end
        end
    end

    // NOTE: the stage-1 product is pure datapath qualified by v1, so it is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (rdy1 && bus.in_valid) p1 <= prod;
    end

    // Set on output acceptance takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             ovf_sticky <= 1'b0;
        else if (v2 && bus.out_ready && |ovf_q) ovf_sticky <= 1'b1;
        else if (ovf_clr)                       ovf_sticky <= 1'b0;
    end
endmodule

// File: tb/tb_renorm_pipe.sv
// Directed bench for renorm_pipe: a 13-bit-output instance for datapath/handshake
// and a 12-bit-output instance for overflow, wrap/saturate and sticky behaviour.
module tb_renorm_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    renorm_if #(.LANES(4), .IN_W(10), .OUT_W(13)) ifa ();
    renorm_if #(.LANES(4), .IN_W(10), .OUT_W(12)) ifb ();

    logic clr_a, clr_b, sticky_a, sticky_b;

    renorm_pipe #(.LANES(4), .IN_W(10), .OUT_W(13), .SHIFT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa), .ovf_clr(clr_a), .ovf_sticky(sticky_a)
    );
    renorm_pipe #(.LANES(4), .IN_W(10), .OUT_W(12), .SHIFT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb), .ovf_clr(clr_b), .ovf_sticky(sticky_b)
    );

    int errors = 0;
    int checks = 0;
    logic [51:0] mon_q[$];
    logic [1:0]  modes[3] = '{2'd1, 2'd2, 2'd3};
    int          vals[3]  = '{400, 100, 500};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] vin(int l0, int l1, int l2, int l3);
        logic [3:0][9:0] r;
        r[0] = 10'(l0); r[1] = 10'(l1); r[2] = 10'(l2); r[3] = 10'(l3);
        return r;
    endfunction

    function automatic logic [51:0] v13(int l0, int l1, int l2, int l3);
        logic [3:0][12:0] r;
        r[0] = 13'(l0); r[1] = 13'(l1); r[2] = 13'(l2); r[3] = 13'(l3);
        return r;
    endfunction

    function automatic logic [47:0] v12(int l0, int l1, int l2, int l3);
        logic [3:0][11:0] r;
        r[0] = 12'(l0); r[1] = 12'(l1); r[2] = 12'(l2); r[3] = 12'(l3);
        return r;
    endfunction

    // Accepted output beats of instance A, sampled half a cycle before the accepting edge.
    always @(negedge clk) begin
        if (ifa.out_valid && ifa.out_ready) mon_q.push_back(ifa.out_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sent;
        int   cyc;
        logic rdy;
        int   exp_b0;

        rst_n = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_mode = 2'd0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_mode = 2'd0; ifb.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", ifa.out_valid, 0);
        check("rst_out_data",  ifa.out_data,  0);
        check("rst_out_ovf",   ifa.out_ovf,   0);
        check("rst_sticky",    sticky_a,      0);
        check("rst_in_ready",  ifa.in_ready,  1);

        // Mode 0 with extreme inputs: two-cycle latency.
        @(posedge clk); #1;
        ifa.in_valid = 1'b1; ifa.in_mode = 2'd0; ifa.in_data = vin(-512, 511, 3, -1);
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        check("t1_not_yet_valid", ifa.out_valid, 0);
        @(posedge clk); #1;
        check("t1_valid", ifa.out_valid, 1);
        check("t1_data",  ifa.out_data,  v13(-2560, 2044, 15, -4));
        check("t1_ovf",   ifa.out_ovf,   0);
        @(posedge clk); #1;

        // Modes 1/2/3 back to back, output valid every cycle.
        for (int i = 0; i < 3; i++) begin
            ifa.in_valid = 1'b1; ifa.in_mode = modes[i]; ifa.in_data = vin(100, 100, 100, 100);
            @(posedge clk); #1;
            if (i > 0) begin
                check("t2_valid", ifa.out_valid, 1);
                check("t2_data",  ifa.out_data,  v13(vals[i-1], vals[i-1], vals[i-1], vals[i-1]));
            end
        end
        ifa.in_valid = 1'b0;
        @(posedge clk); #1;
        check("t2_valid_last", ifa.out_valid, 1);
        check("t2_data_last",  ifa.out_data,  v13(vals[2], vals[2], vals[2], vals[2]));
        @(posedge clk); #1;
        check("t2_drained", ifa.out_valid, 0);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: 4 bypass beats with out_ready low for 5 cycles.
        mon_q.delete();
        ifa.out_ready = 1'b0;
        ifa.in_mode   = 2'd2;
        sent = 0;
        for (int c = 0; c < 5; c++) begin
            ifa.in_valid = (sent < 4);
            ifa.in_data  = vin(10*sent + 1, 10*sent + 2, 10*sent + 3, -(sent + 1));
            @(negedge clk);
            rdy = ifa.in_ready;
            if (c >= 2) begin
                check("t3_stall_in_ready",  ifa.in_ready,  0);
                check("t3_stall_out_valid", ifa.out_valid, 1);
                check("t3_stall_hold_data", ifa.out_data,  v13(1, 2, 3, -1));
            end
            @(posedge clk);
            if (ifa.in_valid && rdy) sent++;
            #1;
        end
        check("t3_accepted_in_stall", sent, 2);
        ifa.out_ready = 1'b1;
        cyc = 0;
        while ((sent < 4 || mon_q.size() < 4) && cyc < 30) begin
            ifa.in_valid = (sent < 4);
            ifa.in_data  = vin(10*sent + 1, 10*sent + 2, 10*sent + 3, -(sent + 1));
            @(negedge clk);
            rdy = ifa.in_ready;
            @(posedge clk);
            if (ifa.in_valid && rdy) sent++;
            #1;
            cyc++;
        end
        ifa.in_valid = 1'b0;
        check("t3_timeout", (cyc < 30), 1);
        repeat (3) @(posedge clk);
        #1;
        check("t3_count", mon_q.size(), 4);
        for (int k = 0; k < mon_q.size() && k < 4; k++)
            check("t3_order", mon_q[k], v13(10*k + 1, 10*k + 2, 10*k + 3, -(k + 1)));

        // Overflow on the 12-bit instance: -512*5 = -2560 does not fit.
`ifdef RENORM_SAT_EN
        exp_b0 = -2048;
`else
        exp_b0 = 1536;
`endif
        ifb.in_valid = 1'b1; ifb.in_mode = 2'd0; ifb.in_data = vin(-512, 0, 0, 0);
        @(posedge clk); #1;
        ifb.in_valid = 1'b0;
        @(posedge clk); #1;
        check("t4_valid",         ifb.out_valid, 1);
        check("t4_data",          ifb.out_data,  v12(exp_b0, 0, 0, 0));
        check("t4_ovf",           ifb.out_ovf,   4'b0001);
        check("t4_sticky_before", sticky_b,      0);
        @(posedge clk); #1;
        check("t4_sticky_after",  sticky_b,      1);
        check("t4_drained",       ifb.out_valid, 0);
        clr_b = 1'b1;
        @(posedge clk); #1;
        clr_b = 1'b0;
        check("t4_sticky_cleared", sticky_b, 0);

        // Clear held high while an overflowing beat is accepted: set wins.
        clr_b = 1'b1;
        ifb.in_valid = 1'b1; ifb.in_data = vin(0, 0, 511, 0);
        @(posedge clk); #1;
        ifb.in_valid = 1'b0;
        @(posedge clk); #1;
        check("t5_ovf", ifb.out_ovf, 4'b0100);
        check("t5_sticky_before", sticky_b, 0);
        @(posedge clk); #1;
        check("t5_sticky_set_wins", sticky_b, 1);
        clr_b = 1'b0;
        check("t5_a_sticky_never", sticky_a, 0);

        // Reset while both stages hold beats.
        ifa.out_ready = 1'b0;
        ifa.in_mode   = 2'd3;
        ifa.in_valid  = 1'b1;
        ifa.in_data   = vin(7, 7, 7, 7);
        repeat (2) @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
        check("t6_full_valid", ifa.out_valid, 1);
        check("t6_full_in_ready", ifa.in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valid", ifa.out_valid, 0);
        check("t6_async_data",  ifa.out_data,  0);
        @(negedge clk);
        rst_n = 1'b1;
        ifa.out_ready = 1'b1;
        mon_q.delete();
        repeat (6) @(posedge clk);
        #1;
        check("t6_no_stale", mon_q.size(), 0);
        check("t6_in_ready", ifa.in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
